// File: rtl/i2c_byte_rx.sv
// I2C slave receive byte engine: shifts SDA on SCL rises, strobes each byte, drives ACK via open-drain enable.
// Optional macro I2C_BYTE_RX_ADDR_MATCH_EN adds a 7-bit address compare on the first byte after START.
module i2c_byte_rx #(
    parameter int unsigned US   = 1,
    parameter int unsigned HOLD = 3 * US / 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sda,
    input  logic       scl_lohi,
    input  logic       scl_hilo,
    input  logic       sta,
    input  logic       sto,
    input  logic       ack_en,
`ifdef I2C_BYTE_RX_ADDR_MATCH_EN
    input  logic [6:0] addr,
`endif
    output logic [7:0] dat,
    output logic       vld,
    output logic       first,
    output logic       sda_oe
);

    localparam int unsigned HW = (HOLD == 0) ? 1 : $clog2(HOLD + 1);
    localparam logic [HW-1:0] HOLD_V = HW'(HOLD);

    typedef enum logic [1:0] {IDLE, BITS, ACKW, ACKD} state_t;

    state_t        state, state_n;
    logic [6:0]    sr, sr_n;
    logic [2:0]    cnt, cnt_n;
    logic          first_flag, first_flag_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          hold_run, hold_run_n;
    logic          ack_lat, ack_lat_n;
    logic          clk_hi, clk_hi_n;
    logic [7:0]    dat_n;
    logic          vld_n, first_n, sda_oe_n;
    logic [7:0]    byte_w;
    logic          hold_done;

    assign byte_w    = {sr, sda};
    assign hold_done = hold_run && (hold_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            first_flag <= 1'b0;
            hold_cnt   <= '0;
            hold_run   <= 1'b0;
            ack_lat    <= 1'b0;
            clk_hi     <= 1'b0;
            dat        <= '0;
            vld        <= 1'b0;
            first      <= 1'b0;
            sda_oe     <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            cnt        <= cnt_n;
            first_flag <= first_flag_n;
            hold_cnt   <= hold_cnt_n;
            hold_run   <= hold_run_n;
            ack_lat    <= ack_lat_n;
            clk_hi     <= clk_hi_n;
            dat        <= dat_n;
            vld        <= vld_n;
            first      <= first_n;
            sda_oe     <= sda_oe_n;
        end
    end

    always_comb begin
        state_n      = state;
        sr_n         = sr;
        cnt_n        = cnt;
        first_flag_n = first_flag;
        hold_cnt_n   = hold_cnt;
        hold_run_n   = hold_run;
        ack_lat_n    = ack_lat;
        clk_hi_n     = clk_hi;
        dat_n        = dat;
        vld_n        = 1'b0;
        first_n      = 1'b0;
        sda_oe_n     = sda_oe;

        if (sto) begin
            state_n    = IDLE;
            cnt_n      = '0;
            sda_oe_n   = 1'b0;
            hold_run_n = 1'b0;
            clk_hi_n   = 1'b0;
        end else if (sta) begin
            state_n      = BITS;
            cnt_n        = '0;
            first_flag_n = 1'b1;
            sda_oe_n     = 1'b0;
            hold_run_n   = 1'b0;
            clk_hi_n     = 1'b0;
        end else begin
            if (hold_run && (hold_cnt != '0))
                hold_cnt_n = hold_cnt - HW'(1);
            case (state)
                IDLE: ;
                BITS: begin
                    if (scl_lohi) begin
                        sr_n  = byte_w[6:0];
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            dat_n        = byte_w;
                            vld_n        = 1'b1;
                            first_n      = first_flag;
                            first_flag_n = 1'b0;
                            state_n      = ACKW;
`ifdef I2C_BYTE_RX_ADDR_MATCH_EN
                            // sr already holds byte[7:1] here; a foreign address parks us until the next START
                            if (first_flag && (sr != addr))
                                state_n = IDLE;
`endif
                        end
                    end
                end
                ACKW: begin
                    if (hold_done) begin
                        hold_run_n = 1'b0;
                        sda_oe_n   = ack_lat;
                        clk_hi_n   = 1'b0;
                        state_n    = ACKD;
                    end else if (!hold_run && scl_hilo) begin
                        ack_lat_n  = ack_en;
                        hold_cnt_n = HOLD_V;
                        hold_run_n = 1'b1;
                    end
                end
                ACKD: begin
                    if (hold_done) begin
                        hold_run_n = 1'b0;
                        sda_oe_n   = 1'b0;
                        cnt_n      = '0;
                        state_n    = BITS;
                    end else if (!hold_run) begin
                        if (scl_lohi) begin
                            clk_hi_n = 1'b1;
                        end else if (scl_hilo && clk_hi) begin
                            hold_cnt_n = HOLD_V;
                            hold_run_n = 1'b1;
                            clk_hi_n   = 1'b0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_rx.sv
// Self-checking bench for i2c_byte_rx: byte table plus hand-written START/STOP corner sequences,
// received bytes checked against a queue of expected {dat, first}.
module tb_i2c_byte_rx;

    localparam int unsigned US_TB   = 10;
    localparam int unsigned HOLD_TB = 3 * US_TB / 10;

    logic       clk = 1'b0;
    logic       rst, sda, scl_lohi, scl_hilo, sta, sto, ack_en;
    logic [7:0] dat;
    logic       vld, first, sda_oe;
`ifdef I2C_BYTE_RX_ADDR_MATCH_EN
    logic [6:0] addr = 7'h52;
`endif

    i2c_byte_rx #(.US(US_TB)) dut (
        .clk(clk), .rst(rst), .sda(sda), .scl_lohi(scl_lohi), .scl_hilo(scl_hilo),
        .sta(sta), .sto(sto), .ack_en(ack_en),
`ifdef I2C_BYTE_RX_ADDR_MATCH_EN
        .addr(addr),
`endif
        .dat(dat), .vld(vld), .first(first), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       f;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       exp_first;
    } vec_t;

    exp_t q[$];
    vec_t tbl[4];
    int   checks = 0;
    int   failures = 0;
    int   vld_count = 0;
    int   pushed = 0;
    logic tb_first = 1'b0;
    logic idle_m = 1'b1;
    logic [7:0] last_dat = 8'h00;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_lohi();
        scl_lohi = 1'b1; tick(); scl_lohi = 1'b0;
    endtask

    task automatic pulse_hilo();
        scl_hilo = 1'b1; tick(); scl_hilo = 1'b0;
    endtask

    task automatic pulse_sta();
        sta = 1'b1; tick(); sta = 1'b0;
        tb_first = 1'b1;
        idle_m   = 1'b0;
    endtask

    task automatic pulse_sto();
        sto = 1'b1; tick(); sto = 1'b0;
        idle_m = 1'b1;
    endtask

    function automatic logic model_ack(input logic [7:0] d, input logic ae);
`ifdef I2C_BYTE_RX_ADDR_MATCH_EN
        return !idle_m && ae && (!tb_first || (d[7:1] == addr));
`else
        return !idle_m && ae;
`endif
    endfunction

    // Full byte plus ACK slot; stop_ackd returns once the ACK is on the bus
    task automatic send_byte(input logic [7:0] d, input logic ae, input logic ef, input logic stop_ackd);
        logic ea;
        ea = model_ack(d, ae);
        if (!idle_m) begin
            q.push_back('{d, ef});
            pushed++;
            last_dat = d;
        end
        for (int i = 7; i >= 0; i--) begin
            sda = d[i];
            tick();
            pulse_lohi();
            tick();
            if (i > 0) pulse_hilo();
        end
`ifdef I2C_BYTE_RX_ADDR_MATCH_EN
        if (!idle_m && tb_first && (d[7:1] != addr)) idle_m = 1'b1;
`endif
        tb_first = 1'b0;
        ack_en = ae;
        pulse_hilo();
        repeat (HOLD_TB) tick();
        check("ack_hold", 8'(sda_oe), 8'h00);
        tick();
        check("ack_on", 8'(sda_oe), 8'(ea));
        if (stop_ackd) return;
        tick();
        pulse_lohi();
        tick();
        check("ack_high", 8'(sda_oe), 8'(ea));
        pulse_hilo();
        repeat (HOLD_TB) tick();
        check("ack_keep", 8'(sda_oe), 8'(ea));
        tick();
        check("ack_off", 8'(sda_oe), 8'h00);
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst && vld) begin
            vld_count++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_vld: got dat=%h first=%b expected no strobe at %0t", dat, first, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("vld_dat", dat, e.d);
                check("vld_first", 8'(first), 8'(e.f));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        tbl[0] = '{8'hA5, 1'b1, 1'b1};
        tbl[1] = '{8'h3C, 1'b0, 1'b0};
        tbl[2] = '{8'h5A, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 1'b0};

        rst = 1'b1; sda = 1'b1; scl_lohi = 1'b0; scl_hilo = 1'b0;
        sta = 1'b0; sto = 1'b0; ack_en = 1'b0;
        tick(); tick();
        check("rst_dat", dat, 8'h00);
        check("rst_vld", 8'(vld), 8'h00);
        check("rst_first", 8'(first), 8'h00);
        check("rst_oe", 8'(sda_oe), 8'h00);
        rst = 1'b0;
        tick();

        // SCL activity before any START must be ignored
        send_byte(8'h77, 1'b1, 1'b0, 1'b0);

        pulse_sta();
        for (int i = 0; i < 4; i++)
            send_byte(tbl[i].data, tbl[i].ack, tbl[i].exp_first, 1'b0);

        // STOP after four bits discards the partial byte
        for (int i = 0; i < 4; i++) begin
            sda = i[0];
            tick(); pulse_lohi(); tick(); pulse_hilo();
        end
        vc = vld_count;
        pulse_sto();
        check("sto_oe", 8'(sda_oe), 8'h00);
        send_byte(8'h99, 1'b1, 1'b0, 1'b0);
        tick();
        check("sto_no_vld", 8'(vld_count), 8'(vc));
        check("sto_dat_hold", dat, last_dat);

        // Repeated START while ACK is being driven
        pulse_sta();
        send_byte(8'hA4, 1'b1, 1'b1, 1'b1);
        check("rs_oe_before", 8'(sda_oe), 8'h01);
        pulse_sta();
        check("rs_oe_drop", 8'(sda_oe), 8'h00);
        send_byte(8'h81, 1'b1, 1'b1, 1'b0);

        // START coincident with an SCL rise: that bit is dropped
        sda = 1'b1; sta = 1'b1; scl_lohi = 1'b1;
        tick();
        sta = 1'b0; scl_lohi = 1'b0;
        tb_first = 1'b1; idle_m = 1'b0;
        send_byte(8'hA4, 1'b0, 1'b1, 1'b0);
        pulse_sto();

`ifdef I2C_BYTE_RX_ADDR_MATCH_EN
        pulse_sta();
        send_byte(8'hA6, 1'b1, 1'b1, 1'b0);
        vc = vld_count;
        send_byte(8'h11, 1'b1, 1'b0, 1'b0);
        tick();
        check("nomatch_no_vld", 8'(vld_count), 8'(vc));
        pulse_sta();
        send_byte(8'hA4, 1'b1, 1'b1, 1'b0);
        pulse_sto();
`endif

        repeat (5) tick();
        check("pending_vld", 8'(q.size()), 8'h00);
        check("vld_total", 8'(vld_count), 8'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
